// File: rtl/cache_control_if.sv
// CPU-side and physical-memory-side handshakes of the cache sequencer.
// The slave view belongs to cache_control; the master view is its environment.
interface cache_control_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic        mem_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    logic        pmem_resp;

    modport master (
        output mem_read, mem_write, mem_addr, pmem_resp,
        input  mem_resp, pmem_read, pmem_write, pmem_address
    );

    modport slave (
        input  mem_read, mem_write, mem_addr, pmem_resp,
        output mem_resp, pmem_read, pmem_write, pmem_address
    );
endinterface

// File: rtl/cache_control.sv
// Sequencing FSM for a 4-way, 16-set, 32-byte-line cache with tree pseudo-LRU.
// Handles hit detection, victim choice, write-back and fill through one memory port.
module cache_control (
    input  logic                 clk,
    input  logic                 rst,
    cache_control_if.slave       bus,
    input  logic [22:0]          tag1_out,
    input  logic [22:0]          tag2_out,
    input  logic [22:0]          tag3_out,
    input  logic [22:0]          tag4_out,
    input  logic [3:0]           valid_out,
    input  logic [3:0]           dirty_out,
    input  logic [2:0]           lru_out,
    output logic [3:0]           ld_tag,
    output logic [3:0]           ld_valid,
    output logic [3:0]           ld_dirty,
    output logic [3:0]           dirty_in,
    output logic [3:0]           valid_in,
    output logic [7:0]           data_arr_we_ctrl,
    output logic [3:0]           data_arr_datain_ctrl,
    output logic [1:0]           cacheline_out_ctrl,
    output logic                 ld_lru,
    output logic [2:0]           lru_in
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPARE   = 2'd1,
        WRITEBACK = 2'd2,
        FILL      = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic [1:0]  victim_r, victim_s;
    logic [22:0] addr_tag_s;
    logic [3:0]  addr_index_s;
    logic        req_s;
    logic [3:0]  hit_s;
    logic        hit_any_s;
    logic [1:0]  hit_way_s;
    logic [1:0]  pick_s;
    logic        pick_dirty_s;
    logic [22:0] victim_tag_s;
    logic        offset_unused_s;

    // Lowest invalid way first; with a full set the tree bits choose the colder pair then way.
    function automatic logic [1:0] pick_victim(input logic [3:0] valid, input logic [2:0] lru);
        logic [1:0] way;
        if (!valid[0])      way = 2'd0;
        else if (!valid[1]) way = 2'd1;
        else if (!valid[2]) way = 2'd2;
        else if (!valid[3]) way = 2'd3;
        else if (!lru[0])   way = lru[1] ? 2'd1 : 2'd0;
        else                way = lru[2] ? 2'd3 : 2'd2;
        return way;
    endfunction

    function automatic logic [2:0] lru_touch(input logic [1:0] way, input logic [2:0] lru);
        logic [2:0] nxt;
        nxt = lru;
        case (way)
            2'd0:    begin nxt[0] = 1'b1; nxt[1] = 1'b1; end
            2'd1:    begin nxt[0] = 1'b1; nxt[1] = 1'b0; end
            2'd2:    begin nxt[0] = 1'b0; nxt[2] = 1'b1; end
            2'd3:    begin nxt[0] = 1'b0; nxt[2] = 1'b0; end
            default: nxt = lru;
        endcase
        return nxt;
    endfunction

    function automatic logic [3:0] way_onehot(input logic [1:0] way);
        return 4'b0001 << way;
    endfunction

    function automatic logic [7:0] we_field(input logic [1:0] way, input logic [1:0] code);
        return {6'd0, code} << {way, 1'b0};
    endfunction

    assign addr_tag_s      = bus.mem_addr[31:9];
    assign addr_index_s    = bus.mem_addr[8:5];
    assign offset_unused_s = ^bus.mem_addr[4:0];
    assign req_s           = bus.mem_read | bus.mem_write;
    assign hit_any_s       = |hit_s;
    assign pick_s          = pick_victim(valid_out, lru_out);
    assign pick_dirty_s    = valid_out[pick_s] & dirty_out[pick_s];

    // Tag match per way and lowest-index winner among simultaneous hits.
    always_comb begin
        hit_s[0] = valid_out[0] & (tag1_out == addr_tag_s);
        hit_s[1] = valid_out[1] & (tag2_out == addr_tag_s);
        hit_s[2] = valid_out[2] & (tag3_out == addr_tag_s);
        hit_s[3] = valid_out[3] & (tag4_out == addr_tag_s);
        if (hit_s[0])      hit_way_s = 2'd0;
        else if (hit_s[1]) hit_way_s = 2'd1;
        else if (hit_s[2]) hit_way_s = 2'd2;
        else               hit_way_s = 2'd3;
    end

    // Stored tag of the latched victim, used to rebuild the write-back address.
    always_comb begin
        case (victim_r)
            2'd0:    victim_tag_s = tag1_out;
            2'd1:    victim_tag_s = tag2_out;
            2'd2:    victim_tag_s = tag3_out;
            2'd3:    victim_tag_s = tag4_out;
            default: victim_tag_s = tag1_out;
        endcase
    end

    // Next-state and Mealy outputs; a simultaneous read and write is handled as a write.
    always_comb begin
        state_s              = state_r;
        victim_s             = victim_r;
        bus.mem_resp         = 1'b0;
        bus.pmem_read        = 1'b0;
        bus.pmem_write       = 1'b0;
        bus.pmem_address     = 32'd0;
        ld_tag               = 4'd0;
        ld_valid             = 4'd0;
        ld_dirty             = 4'd0;
        dirty_in             = 4'd0;
        valid_in             = 4'hF;
        data_arr_we_ctrl     = 8'd0;
        data_arr_datain_ctrl = 4'd0;
        cacheline_out_ctrl   = 2'd0;
        ld_lru               = 1'b0;
        lru_in               = 3'd0;
        case (state_r)
            IDLE: begin
                if (req_s) state_s = COMPARE;
                else       state_s = IDLE;
            end
            COMPARE: begin
                if (!req_s) begin
                    state_s = IDLE;
                end else if (hit_any_s) begin
                    bus.mem_resp       = 1'b1;
                    cacheline_out_ctrl = hit_way_s;
                    ld_lru             = 1'b1;
                    lru_in             = lru_touch(hit_way_s, lru_out);
                    state_s            = IDLE;
                    if (bus.mem_write) begin
                        data_arr_we_ctrl     = we_field(hit_way_s, 2'b10);
                        data_arr_datain_ctrl = way_onehot(hit_way_s);
                        ld_dirty             = way_onehot(hit_way_s);
                        dirty_in             = way_onehot(hit_way_s);
                    end else begin
                        data_arr_we_ctrl     = 8'd0;
                    end
                end else begin
                    victim_s = pick_s;
                    if (pick_dirty_s) state_s = WRITEBACK;
                    else              state_s = FILL;
                end
            end
            WRITEBACK: begin
                bus.pmem_write     = 1'b1;
                cacheline_out_ctrl = victim_r;
                bus.pmem_address   = {victim_tag_s, addr_index_s, 5'd0};
                if (bus.pmem_resp) state_s = FILL;
                else               state_s = WRITEBACK;
            end
            FILL: begin
                bus.pmem_read    = 1'b1;
                bus.pmem_address = {bus.mem_addr[31:5], 5'd0};
                if (bus.pmem_resp) begin
                    data_arr_we_ctrl = we_field(victim_r, 2'b01);
                    ld_tag           = way_onehot(victim_r);
                    ld_valid         = way_onehot(victim_r);
                    ld_dirty         = way_onehot(victim_r);
                    state_s          = COMPARE;
                end else begin
                    state_s          = FILL;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State and victim registers; reset drops any in-flight memory request at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            victim_r <= 2'd0;
        end else begin
            state_r  <= state_s;
            victim_r <= victim_s;
        end
    end

endmodule

// File: tb/tb_cache_control.sv
// Self-checking bench for cache_control: a datapath array model feeds the DUT and a
// transaction-level cache model predicts hits, victims, memory traffic and latency.
module tb_cache_control;

    logic        clk = 1'b0;
    logic        rst;
    logic        dp_rst;
    logic [22:0] tag1_out, tag2_out, tag3_out, tag4_out;
    logic [3:0]  valid_out, dirty_out;
    logic [2:0]  lru_out;
    logic [3:0]  ld_tag, ld_valid, ld_dirty, dirty_in, valid_in;
    logic [7:0]  data_arr_we_ctrl;
    logic [3:0]  data_arr_datain_ctrl;
    logic [1:0]  cacheline_out_ctrl;
    logic        ld_lru;
    logic [2:0]  lru_in;

    int n_pass;
    int n_total;

    // Datapath arrays as the DUT sees them
    logic [22:0] dp_tag   [16][4];
    logic [3:0]  dp_valid [16];
    logic [3:0]  dp_dirty [16];
    logic [2:0]  dp_lru   [16];
    logic [3:0]  dp_idx;

    // Reference cache contents
    logic [22:0] ref_tag   [16][4];
    logic [3:0]  ref_valid [16];
    logic [3:0]  ref_dirty [16];
    logic [2:0]  ref_lru   [16];

    cache_control_if bus_if();

    cache_control dut (
        .clk                  (clk),
        .rst                  (rst),
        .bus                  (bus_if),
        .tag1_out             (tag1_out),
        .tag2_out             (tag2_out),
        .tag3_out             (tag3_out),
        .tag4_out             (tag4_out),
        .valid_out            (valid_out),
        .dirty_out            (dirty_out),
        .lru_out              (lru_out),
        .ld_tag               (ld_tag),
        .ld_valid             (ld_valid),
        .ld_dirty             (ld_dirty),
        .dirty_in             (dirty_in),
        .valid_in             (valid_in),
        .data_arr_we_ctrl     (data_arr_we_ctrl),
        .data_arr_datain_ctrl (data_arr_datain_ctrl),
        .cacheline_out_ctrl   (cacheline_out_ctrl),
        .ld_lru               (ld_lru),
        .lru_in               (lru_in)
    );

    always #5 clk = ~clk;

    assign dp_idx    = bus_if.mem_addr[8:5];
    assign tag1_out  = dp_tag[dp_idx][0];
    assign tag2_out  = dp_tag[dp_idx][1];
    assign tag3_out  = dp_tag[dp_idx][2];
    assign tag4_out  = dp_tag[dp_idx][3];
    assign valid_out = dp_valid[dp_idx];
    assign dirty_out = dp_dirty[dp_idx];
    assign lru_out   = dp_lru[dp_idx];

    // Array loads commit on the rising edge, as in the real datapath.
    always @(posedge clk or posedge dp_rst) begin
        if (dp_rst) begin
            for (int s = 0; s < 16; s++) begin
                for (int w = 0; w < 4; w++) dp_tag[s][w] <= 23'd0;
                dp_valid[s] <= 4'd0;
                dp_dirty[s] <= 4'd0;
                dp_lru[s]   <= 3'd0;
            end
        end else begin
            for (int w = 0; w < 4; w++) begin
                if (ld_tag[w])   dp_tag[dp_idx][w]   <= bus_if.mem_addr[31:9];
                if (ld_valid[w]) dp_valid[dp_idx][w] <= valid_in[w];
                if (ld_dirty[w]) dp_dirty[dp_idx][w] <= dirty_in[w];
            end
            if (ld_lru) dp_lru[dp_idx] <= lru_in;
        end
    end

    function automatic int model_victim(input logic [3:0] v, input logic [2:0] l);
        for (int w = 0; w < 4; w++) begin
            if (!v[w]) return w;
        end
        if (l[0] == 1'b0) return l[1] ? 1 : 0;
        return l[2] ? 3 : 2;
    endfunction

    function automatic logic [2:0] model_touch(input logic [2:0] l, input int w);
        logic [2:0] n;
        n    = l;
        n[0] = (w < 2);
        if (w < 2) n[1] = (w == 0);
        else       n[2] = (w == 2);
        return n;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        dp_rst = 1'b1;
        bus_if.mem_read = 1'b0;
        bus_if.mem_write = 1'b0;
        bus_if.mem_addr = 32'd0;
        bus_if.pmem_resp = 1'b0;
        for (int s = 0; s < 16; s++) begin
            for (int w = 0; w < 4; w++) ref_tag[s][w] = 23'd0;
            ref_valid[s] = 4'd0;
            ref_dirty[s] = 4'd0;
            ref_lru[s]   = 3'd0;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [72:0] obs, exp_v;
        exp_v = {35'd0, 16'd0, 4'hF, 8'd0, 4'd0, 2'd0, 1'b0, 3'd0};
        do_reset();
        #1;
        obs = {bus_if.mem_resp, bus_if.pmem_read, bus_if.pmem_write, bus_if.pmem_address,
               ld_tag, ld_valid, ld_dirty, dirty_in, valid_in, data_arr_we_ctrl,
               data_arr_datain_ctrl, cacheline_out_ctrl, ld_lru, lru_in};
        n_total++;
        if (obs !== exp_v) $display("FAIL reset_outputs: got %h want %h", obs, exp_v);
        else n_pass++;
        rst = 1'b0;
        dp_rst = 1'b0;
        @(negedge clk);
        #1;
        obs = {bus_if.mem_resp, bus_if.pmem_read, bus_if.pmem_write, bus_if.pmem_address,
               ld_tag, ld_valid, ld_dirty, dirty_in, valid_in, data_arr_we_ctrl,
               data_arr_datain_ctrl, cacheline_out_ctrl, ld_lru, lru_in};
        n_total++;
        if (obs !== exp_v) $display("FAIL idle_after_reset: got %h want %h", obs, exp_v);
        else n_pass++;
    endtask

    // One CPU access: drives the request, plays memory, checks against the model.
    task automatic run_access(input logic [31:0] addr, input logic rd, input logic wr);
        logic [3:0]  idx, oh;
        logic [22:0] tg;
        int          hw, vw, cyc, cnt, d, resp_cyc, fill_resp_cyc, exp_lat;
        logic        miss, wb_exp, done, wb_seen, fill_seen, resp_next;
        logic        idle_bad, proto_bad, prev_w, prev_r;
        logic [31:0] wb_addr, fill_addr, wb_exp_addr, fill_exp_addr;
        logic [1:0]  vw2, wb_way;
        logic [2:0]  lru_exp;
        logic [27:0] f_strobe, f_exp, r_wr, r_wr_exp;
        logic [14:0] r_misc, r_misc_exp;
        logic [7:0]  we01, we10;

        idx = addr[8:5];
        tg  = addr[31:9];
        hw  = -1;
        for (int w = 3; w >= 0; w--) begin
            if (ref_valid[idx][w] && ref_tag[idx][w] == tg) hw = w;
        end
        miss = (hw < 0);
        vw   = miss ? model_victim(ref_valid[idx], ref_lru[idx]) : hw;
        vw2  = vw[1:0];
        oh   = 4'b0001 << vw2;
        we01 = 8'd1 << (2 * vw);
        we10 = 8'd2 << (2 * vw);
        wb_exp        = miss && ref_valid[idx][vw2] && ref_dirty[idx][vw2];
        wb_exp_addr   = wb_exp ? {ref_tag[idx][vw2], idx, 5'd0} : 32'd0;
        fill_exp_addr = miss ? {addr[31:5], 5'd0} : 32'd0;
        lru_exp       = model_touch(ref_lru[idx], vw);

        @(negedge clk);
        bus_if.mem_addr  = addr;
        bus_if.mem_read  = rd;
        bus_if.mem_write = wr;
        bus_if.pmem_resp = 1'b0;
        done = 1'b0; wb_seen = 1'b0; fill_seen = 1'b0; resp_next = 1'b0;
        idle_bad = 1'b0; proto_bad = 1'b0; prev_w = 1'b0; prev_r = 1'b0;
        wb_addr = 32'd0; fill_addr = 32'd0; wb_way = 2'd0;
        f_strobe = 28'd0; r_wr = 28'd0; r_misc = 15'd0;
        resp_cyc = -1; fill_resp_cyc = -10; cnt = 0;
        d = int'($urandom_range(1, 3));
        cyc = 0;
        while (!done && cyc < 100) begin
            if (cyc > 0) begin
                @(negedge clk);
                bus_if.pmem_resp = resp_next;
            end
            #1;
            resp_next = 1'b0;
            if (cyc == 0)
                idle_bad = bus_if.mem_resp | bus_if.pmem_read | bus_if.pmem_write | ld_lru |
                           (|ld_tag) | (|ld_valid) | (|ld_dirty) | (|data_arr_we_ctrl);
            if (bus_if.pmem_read && bus_if.pmem_write) proto_bad = 1'b1;
            if (prev_w && bus_if.pmem_write) proto_bad = 1'b1;
            if (prev_r && bus_if.pmem_read) proto_bad = 1'b1;
            prev_w = bus_if.pmem_write && bus_if.pmem_resp;
            prev_r = bus_if.pmem_read && bus_if.pmem_resp;
            if (bus_if.pmem_write) begin
                if (!wb_seen) begin
                    wb_addr = bus_if.pmem_address;
                    wb_way  = cacheline_out_ctrl;
                end
                wb_seen = 1'b1;
                if (fill_seen) proto_bad = 1'b1;
            end
            if (bus_if.pmem_read && !fill_seen) begin
                fill_addr = bus_if.pmem_address;
                fill_seen = 1'b1;
            end
            if (bus_if.pmem_read && bus_if.pmem_resp) begin
                fill_resp_cyc = cyc;
                f_strobe = {ld_tag, ld_valid, ld_dirty, dirty_in, data_arr_we_ctrl, data_arr_datain_ctrl};
            end
            if ((bus_if.pmem_read || bus_if.pmem_write) && !bus_if.pmem_resp) begin
                cnt++;
                if (cnt >= d) begin
                    resp_next = 1'b1;
                    cnt = 0;
                    d = int'($urandom_range(1, 3));
                end
            end
            if (bus_if.mem_resp) begin
                resp_cyc = cyc;
                r_misc = {cacheline_out_ctrl, ld_lru, lru_in, bus_if.pmem_read | bus_if.pmem_write,
                          ld_tag, ld_valid};
                r_wr = {data_arr_we_ctrl, data_arr_datain_ctrl, ld_dirty, dirty_in, 4'd0};
                done = 1'b1;
            end
            cyc++;
        end

        n_total++;
        if (!done) $display("FAIL access_timeout addr=%h: no mem_resp in 100 cycles", addr);
        else n_pass++;
        n_total++;
        if (idle_bad !== 1'b0) $display("FAIL idle_quiet addr=%h: outputs active in IDLE", addr);
        else n_pass++;
        n_total++;
        if (proto_bad !== 1'b0) $display("FAIL pmem_protocol addr=%h: overlap or held past resp", addr);
        else n_pass++;
        exp_lat = miss ? fill_resp_cyc + 1 : 1;
        n_total++;
        if (resp_cyc != exp_lat) $display("FAIL latency addr=%h: got %0d want %0d", addr, resp_cyc, exp_lat);
        else n_pass++;
        n_total++;
        if ({wb_seen, wb_addr, wb_way} !== {wb_exp, wb_exp_addr, wb_exp ? vw2 : 2'd0})
            $display("FAIL writeback addr=%h: got seen=%b a=%h way=%0d want seen=%b a=%h way=%0d",
                     addr, wb_seen, wb_addr, wb_way, wb_exp, wb_exp_addr, vw2);
        else n_pass++;
        n_total++;
        if ({fill_seen, fill_addr} !== {miss, fill_exp_addr})
            $display("FAIL fill addr=%h: got seen=%b a=%h want seen=%b a=%h",
                     addr, fill_seen, fill_addr, miss, fill_exp_addr);
        else n_pass++;
        if (miss) begin
            f_exp = {oh, oh, oh, 4'd0, we01, 4'd0};
            n_total++;
            if (f_strobe !== f_exp) $display("FAIL fill_strobes addr=%h: got %h want %h", addr, f_strobe, f_exp);
            else n_pass++;
        end
        r_misc_exp = {vw2, 1'b1, lru_exp, 1'b0, 8'd0};
        n_total++;
        if (r_misc !== r_misc_exp) $display("FAIL hit_outputs addr=%h: got %h want %h", addr, r_misc, r_misc_exp);
        else n_pass++;
        r_wr_exp = wr ? {we10, oh, oh, oh, 4'd0} : 28'd0;
        n_total++;
        if (r_wr !== r_wr_exp) $display("FAIL write_strobes addr=%h: got %h want %h", addr, r_wr, r_wr_exp);
        else n_pass++;

        if (miss) begin
            ref_tag[idx][vw2]   = tg;
            ref_valid[idx][vw2] = 1'b1;
            ref_dirty[idx][vw2] = 1'b0;
        end
        if (wr) ref_dirty[idx][vw2] = 1'b1;
        ref_lru[idx] = lru_exp;
    endtask

    task automatic go_idle();
        @(negedge clk);
        bus_if.mem_read  = 1'b0;
        bus_if.mem_write = 1'b0;
        bus_if.pmem_resp = 1'b0;
    endtask

    task automatic test_cold_and_hits();
        run_access(32'h0000_0040, 1'b1, 1'b0);
        run_access(32'h0000_0040, 1'b1, 1'b0);
        run_access(32'h0000_0044, 1'b0, 1'b1);
        run_access(32'h0000_0048, 1'b1, 1'b1);
        go_idle();
    endtask

    task automatic test_set_fill();
        do_reset();
        rst = 1'b0;
        dp_rst = 1'b0;
        for (int t = 1; t <= 4; t++) run_access({23'(t), 4'd2, 5'd0}, 1'b0, 1'b1);
        run_access({23'd5, 4'd2, 5'd0}, 1'b1, 1'b0);
        run_access({23'd2, 4'd2, 5'd4}, 1'b1, 1'b0);
        go_idle();
    endtask

    task automatic test_reset_mid_fill();
        logic        seen;
        logic [31:0] a;
        logic [16:0] obs;
        a = {23'd7, 4'd15, 5'd0};
        @(negedge clk);
        bus_if.mem_addr  = a;
        bus_if.mem_read  = 1'b1;
        bus_if.mem_write = 1'b0;
        bus_if.pmem_resp = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            #1;
            seen = bus_if.pmem_read;
        end
        n_total++;
        if (seen !== 1'b1) $display("FAIL fill_start_timeout: pmem_read got %b want 1", seen);
        else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if ({bus_if.pmem_read, bus_if.pmem_write} !== 2'b00)
            $display("FAIL reset_drops_pmem: got %b want 00", {bus_if.pmem_read, bus_if.pmem_write});
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        bus_if.mem_read = 1'b0;
        @(negedge clk);
        bus_if.pmem_resp = 1'b1;
        #1;
        obs = {ld_tag, ld_valid, data_arr_we_ctrl, bus_if.mem_resp};
        n_total++;
        if (obs !== 17'd0) $display("FAIL stale_pmem_resp: got %h want 0", obs);
        else n_pass++;
        @(negedge clk);
        bus_if.pmem_resp = 1'b0;
        run_access(a, 1'b1, 1'b0);
        go_idle();
    endtask

    task automatic test_random();
        logic [31:0] a;
        int          op;
        for (int k = 0; k < 80; k++) begin
            a  = {23'($urandom_range(0, 5)), 4'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
            op = int'($urandom_range(0, 2));
            run_access(a, op != 1, op != 0);
        end
        go_idle();
    endtask

    task automatic test_final_state();
        logic [102:0] got, want;
        for (int s = 0; s < 16; s++) begin
            got  = {dp_tag[s][0], dp_tag[s][1], dp_tag[s][2], dp_tag[s][3],
                    dp_valid[s], dp_dirty[s], dp_lru[s]};
            want = {ref_tag[s][0], ref_tag[s][1], ref_tag[s][2], ref_tag[s][3],
                    ref_valid[s], ref_dirty[s], ref_lru[s]};
            n_total++;
            if (got !== want) $display("FAIL array_state set=%0d: got %h want %h", s, got, want);
            else n_pass++;
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_cold_and_hits();
        test_set_fill();
        test_reset_mid_fill();
        test_random();
        test_final_state();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cache_control.md
# cache_control

Sequencing FSM for the 4-way set-associative cache datapath: 16 sets, 32-byte lines, 23-bit tags, 3-bit tree pseudo-LRU. It accepts one CPU-side read or write at a time, performs hit detection and victim selection, and drives the datapath's array loads, write-enable and data muxes. It runs 256-bit write-back and fill transfers to physical memory through a single-outstanding req/resp handshake. It is instantiated beside the datapath inside the cache top.

## Interface
- s_offset, 5, byte-offset bits
- s_index, 4, set-index bits
- s_tag, 23, tag bits (32 - s_offset - s_index)

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- mem_read / mem_write  in  1  CPU request; held with mem_addr until mem_resp
- mem_addr  in  32  CPU byte address, also fed to the datapath
- mem_resp  out  1  one-cycle completion pulse
- pmem_read / pmem_write  out  1  memory request; held until pmem_resp
- pmem_address  out  32  line-aligned memory address
- pmem_resp  in  1  memory completion pulse
- tag1_out..tag4_out  in  s_tag each  stored tags of the indexed set
- valid_out, dirty_out  in  4  bit i = way i+1
- lru_out  in  3  LRU bits of the indexed set
- ld_tag, ld_valid, ld_dirty  out  4  per-way load strobes
- dirty_in  out  4  per-way dirty value
- valid_in  out  4  per-way valid value, always 4'hF
- data_arr_we_ctrl  out  8  bits [2i+1:2i] for way i+1: 00 none, 01 full line, 10 bus_en
- data_arr_datain_ctrl  out  4  per way: 0 cacheline_in (fill), 1 bus_in (CPU write)
- cacheline_out_ctrl  out  2  way driving data_cacheline_out
- ld_lru  out  1  LRU array load
- lru_in  out  3  new LRU value

## Operation
- States: IDLE, COMPARE, WRITEBACK, FILL.
- IDLE: on mem_read|mem_write, go to COMPARE. No outputs are asserted.
- COMPARE: hit[i] = valid_out[i] & (tag(i+1)_out == mem_addr[31:9]). If several ways hit, the lowest index wins.
  - Read hit:
    - mem_resp=1; cacheline_out_ctrl = hit way.
    - ld_lru=1; go to IDLE.
  - Write hit: as for a read hit, plus:
    - hit way's we_ctrl=10 and datain_ctrl=1.
    - ld_dirty=1 and dirty_in=1 for that way.
  - Miss: select a victim.
    - If victim valid & dirty, go to WRITEBACK; otherwise go to FILL.
    - The victim is latched in a 2-bit register for the rest of the miss.
- Victim: the lowest-index invalid way. If all ways are valid, walk the tree:
  - lru[0]=0 → pair {1,2}: lru[1]=0 → way1, else way2.
  - lru[0]=1 → pair {3,4}: lru[2]=0 → way3, else way4.
- LRU update on hit (unlisted bits keep lru_out):
  - way1: lru[0]=1, lru[1]=1
  - way2: lru[0]=1, lru[1]=0
  - way3: lru[0]=0, lru[2]=1
  - way4: lru[0]=0, lru[2]=0
- WRITEBACK:
  - pmem_write=1; cacheline_out_ctrl = victim.
  - pmem_address = {victim tag, mem_addr[8:5], 5'b0}.
  - On pmem_resp, go to FILL.
- FILL:
  - pmem_read=1; pmem_address = {mem_addr[31:5], 5'b0}.
  - On pmem_resp, for the victim way: we_ctrl=01, datain_ctrl=0, ld_tag=1, ld_valid=1, ld_dirty=1 with dirty_in=0. Go to COMPARE.
  - Re-entering COMPARE guarantees a hit, which completes the request and updates LRU.
- Simultaneous mem_read & mem_write: treated as a write.

## Timing
- Reset (asynchronous): state=IDLE, victim register=0. All outputs 0 except valid_in=4'hF.
- Reset mid-miss: pmem_read/pmem_write drop immediately. Any subsequent pmem_resp is ignored.
- All outputs are combinational from state and inputs (Mealy). Array loads commit on the next rising edge.
- Hit latency: request seen at edge 0, mem_resp during cycle 1.
- Clean miss: mem_resp one cycle after the FILL pmem_resp cycle.
- Dirty miss: WRITEBACK + FILL + 1 cycle.
- pmem_read and pmem_write are never asserted together. Each stays high through the pmem_resp cycle and is low the cycle after.
- mem_resp is never high for two consecutive cycles. The next request is sampled in IDLE.
- pmem_resp in IDLE or COMPARE: ignored.

## Test plan
- Cold read miss at 0x0000_0040 after reset: pmem_read with pmem_address=0x40. After pmem_resp: way1 ld_tag/ld_valid, we_ctrl[1:0]=01, then mem_resp. lru_in=3'b011.
- Read hit to the same line: mem_resp in the cycle after the request, no pmem activity, cacheline_out_ctrl=0.
- Write hit to 0x44:
  - we_ctrl[1:0]=10, datain_ctrl[0]=1.
  - ld_dirty[0]=1, dirty_in[0]=1.
  - mem_resp after 1 cycle.
- Fill all 4 ways of set 2 with tags 1..4, then access tag 5:
  - Victim follows the tree (way1 after accesses in order 1,2,3,4).
  - A dirty victim yields pmem_write to {old tag, 4'd2, 5'b0} before pmem_read.
- Assert rst during FILL with pmem_read high: pmem_read low with no clock edge. A pmem_resp pulse afterwards causes no array load. A new read restarts from IDLE.
- mem_read & mem_write both high on a hit: write-hit outputs are produced.
